i2c_slave_regfile: RTL and testbench

Synthesizable I2C target that owns a parametrised byte-wide register file, clocked entirely in the system domain with oversampled SCL/SDA. It replaces the behavioural slave responder for DUT-level and FPGA runs of the IICMB controller. Over the bus, the IICMB master writes a register pointer and then data, or reads from the pointer with auto-increment. A host-side port exposes write events and provides a backdoor read of the array.

---
 rtl/i2c_slave_pkg.sv | 32 +++
 rtl/i2c_bus_sync.sv | 75 +++++++
 rtl/i2c_slave_regfile.sv | 248 ++++++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_pkg.sv
// Shared state/operation types and sizing helpers for the I2C register-file target.
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR,
        WR_ACK,
        RD,
        RD_ACK,
        HOLD
    } i2c_slave_state_t;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } i2c_op_t;

    localparam int MIN_DEPTH = 2;
    localparam int MAX_DEPTH = 256;

    // Register-pointer width for a given array depth, clamped to the legal range.
    function automatic int ptr_width(input int depth);
        if (depth <= MIN_DEPTH) return 1;
        if (depth >= MAX_DEPTH) return $clog2(MAX_DEPTH);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes raw SCL/SDA into the system clock and emits one-cycle
// SCL edge and START/STOP strobes, with SDA aligned to those strobes.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic scl_prev_q, scl_prev_d;
    logic sda_prev_q, sda_prev_d;
    logic sda_bit_q, sda_bit_d;
    logic scl_rise_q, scl_rise_d;
    logic scl_fall_q, scl_fall_d;
    logic start_q, start_d;
    logic stop_q, stop_d;
    logic scl_s, sda_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // START/STOP need SCL high on both sides of the SDA transition.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
        sda_bit_d  = sda_s;
        scl_rise_d = scl_s & ~scl_prev_q;
        scl_fall_d = ~scl_s & scl_prev_q;
        start_d    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
        stop_d     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    end

    // The idle bus is high, so the chain resets to 1 to avoid phantom events.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            sda_bit_q  <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            sda_bit_q  <= sda_bit_d;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    assign sda_s_o    = sda_bit_q;
    assign scl_rise_o = scl_rise_q;
    assign scl_fall_o = scl_fall_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target owning a byte-wide register file: pointer write, auto-increment
// write and read, plus a host-side write monitor and backdoor read port.
module i2c_slave_regfile
    import i2c_slave_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 7,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    DEPTH       = 16,
    parameter logic [ADDR_WIDTH-1:0] SLAVE_ADDR  = 7'h22,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        scl_i,
    input  logic                        sda_i,
    output logic                        sda_o,
    output logic                        busy_o,
    output logic                        start_o,
    output logic                        stop_o,
    output logic                        wr_strobe_o,
    output logic [ptr_width(DEPTH)-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0]       wr_data_o,
    input  logic [ptr_width(DEPTH)-1:0] mem_addr_i,
    output logic [DATA_WIDTH-1:0]       mem_rdata_o
);

    localparam int PTR_W   = ptr_width(DEPTH);
    localparam int SHIFT_W = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
    localparam int CNT_W   = $clog2(SHIFT_W + 1);

    logic sda_bit, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_sync (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_s_o   (sda_bit),
        .scl_rise_o(scl_rise),
        .scl_fall_o(scl_fall),
        .start_o   (start_det),
        .stop_o    (stop_det)
    );

    i2c_slave_state_t state_q, state_d;
    i2c_op_t          op_q, op_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [SHIFT_W-1:0]    shift_q, shift_d, shift_in;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic                  sda_q, sda_d;
    logic                  busy_q, busy_d;
    logic                  start_q, start_d;
    logic                  stop_q, stop_d;
    logic                  wr_strobe_q, wr_strobe_d;
    logic [PTR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    assign shift_in = {shift_q[SHIFT_W-2:0], sda_bit};

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        sda_d       = sda_q;
        busy_d      = busy_q;
        start_d     = 1'b0;
        stop_d      = 1'b0;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        mem_d       = mem_q;
        mem_rdata_d = mem_q[mem_addr_i];

        case (state_q)
            IDLE, HOLD: begin
                sda_d = 1'b1;
            end
            ADDR: begin
                if (scl_rise) begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(ADDR_WIDTH)) begin
                        bit_cnt_d = '0;
                        if (shift_in[ADDR_WIDTH:1] == SLAVE_ADDR) begin
                            state_d = ADDR_ACK;
                            op_d    = i2c_op_t'(shift_in[0]);
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            // First SCL fall starts our ACK low; the second one ends the ACK clock.
            ADDR_ACK, PTR_ACK, WR_ACK: begin
                if (scl_fall) begin
                    if (bit_cnt_q == '0) begin
                        sda_d     = 1'b0;
                        bit_cnt_d = CNT_W'(1);
                    end else begin
                        bit_cnt_d = '0;
                        sda_d     = 1'b1;
                        if (state_q == ADDR_ACK && op_q == READ) begin
                            tx_d    = mem_q[ptr_q];
                            sda_d   = mem_q[ptr_q][DATA_WIDTH-1];
                            state_d = RD;
                        end else if (state_q == ADDR_ACK) begin
                            state_d = PTR;
                        end else begin
                            state_d = WR;
                        end
                    end
                end
            end
            PTR: begin
                if (scl_rise) begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        ptr_d     = shift_in[PTR_W-1:0];
                        state_d   = PTR_ACK;
                    end
                end
            end
            WR: begin
                if (scl_rise) begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_d    = '0;
                        mem_d[ptr_q] = shift_in[DATA_WIDTH-1:0];
                        wr_strobe_d  = 1'b1;
                        wr_addr_d    = ptr_q;
                        wr_data_d    = shift_in[DATA_WIDTH-1:0];
                        ptr_d        = ptr_q + PTR_W'(1);
                        state_d      = WR_ACK;
                    end
                end
            end
            RD: begin
                if (scl_rise) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end else if (scl_fall) begin
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH)) begin
                        bit_cnt_d = '0;
                        sda_d     = 1'b1;
                        ptr_d     = ptr_q + PTR_W'(1);
                        state_d   = RD_ACK;
                    end else begin
                        tx_d  = {tx_q[DATA_WIDTH-2:0], 1'b0};
                        sda_d = tx_q[DATA_WIDTH-2];
                    end
                end
            end
            RD_ACK: begin
                if (scl_rise) begin
                    if (sda_bit) begin
                        state_d = HOLD;
                    end else begin
                        bit_cnt_d = CNT_W'(1);
                    end
                end else if (scl_fall && bit_cnt_q == CNT_W'(1)) begin
                    bit_cnt_d = '0;
                    tx_d      = mem_q[ptr_q];
                    sda_d     = mem_q[ptr_q][DATA_WIDTH-1];
                    state_d   = RD;
                end
            end
            default: begin
                state_d = IDLE;
                sda_d   = 1'b1;
            end
        endcase

        // Bus conditions abort whatever byte is in flight.
        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_d     = 1'b1;
            busy_d    = 1'b1;
            start_d   = 1'b1;
        end
        if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sda_d     = 1'b1;
            busy_d    = 1'b0;
            stop_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            op_q        <= WRITE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            ptr_q       <= '0;
            sda_q       <= 1'b1;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            mem_rdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            sda_q       <= sda_d;
            busy_q      <= busy_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            mem_rdata_q <= mem_rdata_d;
            mem_q       <= mem_d;
        end
    end

    assign sda_o       = sda_q;
    assign busy_o      = busy_q;
    assign start_o     = start_q;
    assign stop_o      = stop_q;
    assign wr_strobe_o = wr_strobe_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign mem_rdata_o = mem_rdata_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: a bit-banged master on a wired-AND
// SDA line, with monitors on the write port, START/STOP pulses and sda_o.
module tb_i2c_slave_regfile;
    import i2c_slave_pkg::*;

    localparam int QTR = 10;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] exp_data;
    } rd_vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m_scl;
    logic       m_sda;
    logic       sda_bus;
    logic       sda_o, busy_o, start_o, stop_o, wr_strobe_o;
    logic [3:0] wr_addr_o;
    logic [7:0] wr_data_o;
    logic [3:0] mem_addr;
    logic [7:0] mem_rdata_o;

    int n_cmp  = 0;
    int n_fail = 0;

    int          start_cnt   = 0;
    int          stop_cnt    = 0;
    int          sda_low_cnt = 0;
    logic [11:0] wr_log[$];

    assign sda_bus = m_sda & sda_o;

    i2c_slave_regfile dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .scl_i      (m_scl),
        .sda_i      (sda_bus),
        .sda_o      (sda_o),
        .busy_o     (busy_o),
        .start_o    (start_o),
        .stop_o     (stop_o),
        .wr_strobe_o(wr_strobe_o),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o),
        .mem_addr_i (mem_addr),
        .mem_rdata_o(mem_rdata_o)
    );

    always #5 clk = ~clk;

    // Event monitors sample on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        if (start_o) start_cnt++;
        if (stop_o) stop_cnt++;
        if (!sda_o) sda_low_cnt++;
        if (wr_strobe_o) wr_log.push_back({wr_addr_o, wr_data_o});
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input rd_vec_t v, input int idx);
        @(negedge clk);
        mem_addr = v.addr;
        @(negedge clk);
        checkOutput($sformatf("backdoor[%0d] idx %0d", idx, v.addr), mem_rdata_o, v.exp_data);
    endtask

    task automatic check_log(input string name, input int idx, input logic [11:0] exp);
        logic [11:0] act;
        act = (idx < wr_log.size()) ? wr_log[idx] : 12'hFFF;
        checkOutput(name, act, exp);
    endtask

    task automatic q_wait();
        repeat (QTR) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; q_wait();
        m_scl = 1'b1; q_wait();
        m_sda = 1'b0; q_wait();
        m_scl = 1'b0; q_wait();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; q_wait();
        m_scl = 1'b1; q_wait();
        m_sda = 1'b1; q_wait();
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    q_wait();
        m_scl = 1'b1; q_wait(); q_wait();
        m_scl = 1'b0; q_wait();
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; q_wait();
        m_scl = 1'b1; q_wait();
        b = sda_bus;  q_wait();
        m_scl = 1'b0; q_wait();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~ack);
    endtask

    initial begin
        rd_vec_t     vecs[6];
        rd_vec_t     v;
        logic        ack;
        logic        b;
        logic [7:0]  rd;
        int          base;
        int          low_base;

        vecs[0] = '{addr: 4'd3,  exp_data: 8'hA5};
        vecs[1] = '{addr: 4'd4,  exp_data: 8'h5A};
        vecs[2] = '{addr: 4'd15, exp_data: 8'h11};
        vecs[3] = '{addr: 4'd0,  exp_data: 8'h22};
        vecs[4] = '{addr: 4'd1,  exp_data: 8'h33};
        vecs[5] = '{addr: 4'd2,  exp_data: 8'h00};

        rst_n    = 1'b0;
        m_scl    = 1'b1;
        m_sda    = 1'b1;
        mem_addr = 4'd0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset sda_o", sda_o, 1);
        checkOutput("reset busy_o", busy_o, 0);
        checkOutput("reset start_o", start_o, 0);
        checkOutput("reset stop_o", stop_o, 0);
        checkOutput("reset wr_strobe_o", wr_strobe_o, 0);
        checkOutput("reset wr_addr_o", wr_addr_o, 0);
        checkOutput("reset wr_data_o", wr_data_o, 0);
        checkOutput("reset mem_rdata_o", mem_rdata_o, 0);

        // Write pointer 3 then A5, 5A; first START also checks pulse latency.
        $display("[TB] write pointer 0x03, data A5 5A");
        base = wr_log.size();
        @(negedge clk);
        m_sda = 1'b0;
        repeat (3) @(posedge clk);
        #1 checkOutput("start_o latency early", start_o, 0);
        @(posedge clk);
        #1 checkOutput("start_o latency", start_o, 1);
        @(posedge clk);
        #1 checkOutput("start_o width", start_o, 0);
        q_wait();
        m_scl = 1'b0;
        q_wait();
        write_byte(8'h44, ack); checkOutput("t1 addr ack", ack, 1);
        write_byte(8'h03, ack); checkOutput("t1 ptr ack", ack, 1);
        write_byte(8'hA5, ack); checkOutput("t1 data0 ack", ack, 1);
        write_byte(8'h5A, ack); checkOutput("t1 data1 ack", ack, 1);
        checkOutput("t1 busy mid", busy_o, 1);
        bus_stop();
        q_wait();
        checkOutput("t1 busy after stop", busy_o, 0);
        checkOutput("t1 strobe count", wr_log.size() - base, 2);
        check_log("t1 strobe0", base, 12'h3A5);
        check_log("t1 strobe1", base + 1, 12'h45A);
        checkOutput("t1 start count", start_cnt, 1);
        checkOutput("t1 stop count", stop_cnt, 1);

        // Random read: pointer write, repeated START, read two bytes.
        $display("[TB] random read from 0x03");
        base = wr_log.size();
        bus_start();
        write_byte(8'h44, ack); checkOutput("t2 addr ack", ack, 1);
        write_byte(8'h03, ack); checkOutput("t2 ptr ack", ack, 1);
        bus_start();
        write_byte(8'h45, ack); checkOutput("t2 read addr ack", ack, 1);
        read_byte(rd, 1'b1);    checkOutput("t2 read byte0", rd, 8'hA5);
        read_byte(rd, 1'b0);    checkOutput("t2 read byte1", rd, 8'h5A);
        checkOutput("t2 state hold", 32'(dut.state_q), 32'(HOLD));
        checkOutput("t2 busy in hold", busy_o, 1);
        bus_stop();
        q_wait();
        checkOutput("t2 state idle", 32'(dut.state_q), 32'(IDLE));
        checkOutput("t2 busy after stop", busy_o, 0);
        checkOutput("t2 start count", start_cnt, 3);
        checkOutput("t2 stop count", stop_cnt, 2);
        checkOutput("t2 no strobes", wr_log.size() - base, 0);

        // Foreign address 0x23: never ACKed, SDA never pulled.
        $display("[TB] address 0x23 is ignored");
        base     = wr_log.size();
        low_base = sda_low_cnt;
        bus_start();
        write_byte(8'h46, ack); checkOutput("t3 addr nack", ack, 0);
        write_byte(8'h11, ack); checkOutput("t3 data nack", ack, 0);
        checkOutput("t3 state hold", 32'(dut.state_q), 32'(HOLD));
        bus_stop();
        q_wait();
        checkOutput("t3 sda_o low cycles", sda_low_cnt - low_base, 0);
        checkOutput("t3 no strobes", wr_log.size() - base, 0);

        // Pointer wrap: 0x0F, then three bytes land at 15, 0, 1.
        $display("[TB] pointer wrap-around");
        base = wr_log.size();
        bus_start();
        write_byte(8'h44, ack); checkOutput("t4 addr ack", ack, 1);
        write_byte(8'h0F, ack); checkOutput("t4 ptr ack", ack, 1);
        write_byte(8'h11, ack); checkOutput("t4 data0 ack", ack, 1);
        write_byte(8'h22, ack); checkOutput("t4 data1 ack", ack, 1);
        write_byte(8'h33, ack); checkOutput("t4 data2 ack", ack, 1);
        bus_stop();
        q_wait();
        checkOutput("t4 strobe count", wr_log.size() - base, 3);
        check_log("t4 strobe0", base, 12'hF11);
        check_log("t4 strobe1", base + 1, 12'h022);
        check_log("t4 strobe2", base + 2, 12'h133);

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

        // STOP after half a data byte must commit nothing.
        $display("[TB] STOP mid-byte");
        base = wr_log.size();
        bus_start();
        write_byte(8'h44, ack); checkOutput("t5 addr ack", ack, 1);
        write_byte(8'h08, ack); checkOutput("t5 ptr ack", ack, 1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        bus_stop();
        q_wait();
        checkOutput("t5 no strobe", wr_log.size() - base, 0);
        checkOutput("t5 busy after stop", busy_o, 0);
        checkOutput("t5 state idle", 32'(dut.state_q), 32'(IDLE));
        bus_start();
        write_byte(8'h44, ack); checkOutput("t5b addr ack", ack, 1);
        write_byte(8'h08, ack); checkOutput("t5b ptr ack", ack, 1);
        write_byte(8'h77, ack); checkOutput("t5b data ack", ack, 1);
        bus_stop();
        q_wait();
        checkOutput("t5b strobe count", wr_log.size() - base, 1);
        check_log("t5b strobe0", base, 12'h877);
        v = '{addr: 4'd8, exp_data: 8'h77};
        applyStimulus(v, 6);

        // Reset while the slave drives a 0 data bit (bit 6 of A5).
        $display("[TB] reset during read");
        bus_start();
        write_byte(8'h44, ack); checkOutput("t6 addr ack", ack, 1);
        write_byte(8'h03, ack); checkOutput("t6 ptr ack", ack, 1);
        bus_start();
        write_byte(8'h45, ack); checkOutput("t6 read addr ack", ack, 1);
        recv_bit(b);
        checkOutput("t6 first bit", b, 1);
        checkOutput("t6 slave drives 0", sda_o, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 checkOutput("t6 sda_o released in reset cycle", sda_o, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_scl = 1'b1;
        q_wait();
        checkOutput("t6 busy after reset", busy_o, 0);
        checkOutput("t6 state idle", 32'(dut.state_q), 32'(IDLE));
        checkOutput("t6 wr_addr cleared", wr_addr_o, 0);
        checkOutput("t6 wr_data cleared", wr_data_o, 0);
        for (int i = 0; i < 16; i++) begin
            v = '{addr: 4'(i), exp_data: 8'h00};
            applyStimulus(v, 7 + i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
